// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter: owner encoding and counter sizing.
// No logic; no latency.
// No flow control of its own.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    localparam int STALL_CNT_W = 16;

    // The run counter must hold the larger limit, because it saturates there.
    function automatic int run_cnt_w(input int max_run);
        return (max_run < 1) ? 1 : $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_fair.sv
// Picks the CPU or the loader each cycle and bounds how long one side keeps the RAM.
// Grant is combinational (0 cycles); last_owner/run_cnt update on the clock edge.
// The loser of a contended cycle simply waits; the owner is forced to yield after its limit.
module dmem_arb_fair
    import dmem_arb_pkg::*;
#(
    parameter int CPU_MAX_RUN = 4,
    parameter int LDR_MAX_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic ldr_req,
    output logic cpu_gnt,
    output logic ldr_gnt
);

    localparam int RUN_MAX = (CPU_MAX_RUN > LDR_MAX_RUN) ? CPU_MAX_RUN : LDR_MAX_RUN;
    localparam int RW      = run_cnt_w(RUN_MAX);

    owner_e          last_owner;
    logic [RW-1:0]   run_cnt;
    owner_e          gnt_owner;

    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (!rst) begin
            if (cpu_req && ldr_req) begin
                // Under contention the current owner keeps going until it uses up its run.
                if (last_owner == OWN_CPU) begin
                    if (int'(run_cnt) >= CPU_MAX_RUN) ldr_gnt = 1'b1;
                    else                              cpu_gnt = 1'b1;
                end else begin
                    if (int'(run_cnt) >= LDR_MAX_RUN) cpu_gnt = 1'b1;
                    else                              ldr_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req;
                ldr_gnt = ldr_req;
            end
        end
    end

    assign gnt_owner = ldr_gnt ? OWN_LDR : OWN_CPU;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_CPU;
            run_cnt    <= '0;
        end else if (cpu_gnt || ldr_gnt) begin
            if (gnt_owner == last_owner) begin
                if (int'(run_cnt) < RUN_MAX) run_cnt <= run_cnt + 1'b1;
            end else begin
                last_owner <= gnt_owner;
                run_cnt    <= RW'(1);
            end
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between core load/store and the loader port; DMEM_ARB_STATS_EN adds a stall counter.
// CPU beats: 0 cycles. Loader ack in the granted cycle, read data 1 cycle later.
// The core is stalled while the loader owns the RAM; the loader holds its beat until ldr_ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int CPU_MAX_RUN = 4,
    parameter int LDR_MAX_RUN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wd,
    output logic [DW-1:0]          cpu_rd,
    output logic                   cpu_stall,
    input  logic                   ldr_req,
    input  logic                   ldr_we,
    input  logic [AW-1:0]          ldr_addr,
    input  logic [DW-1:0]          ldr_wd,
    output logic                   ldr_ack,
    output logic [DW-1:0]          ldr_rdata,
    output logic                   ldr_rvalid,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_a,
    output logic [DW-1:0]          mem_wd,
    input  logic [DW-1:0]          mem_rd,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } beat_t;

    logic  cpu_gnt;
    logic  ldr_gnt;
    beat_t cpu_beat;
    beat_t ldr_beat;
    beat_t mem_beat;

    dmem_arb_fair #(
        .CPU_MAX_RUN (CPU_MAX_RUN),
        .LDR_MAX_RUN (LDR_MAX_RUN)
    ) u_fair (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .ldr_req (ldr_req),
        .cpu_gnt (cpu_gnt),
        .ldr_gnt (ldr_gnt)
    );

    assign cpu_beat = '{we: cpu_we, a: cpu_addr, wd: cpu_wd};
    assign ldr_beat = '{we: ldr_we, a: ldr_addr, wd: ldr_wd};

    // With no grant the CPU's address stays on the bus, but nothing is written.
    always_comb begin
        mem_beat    = cpu_beat;
        mem_beat.we = 1'b0;
        if (cpu_gnt)      mem_beat = cpu_beat;
        else if (ldr_gnt) mem_beat = ldr_beat;
    end

    assign mem_we    = mem_beat.we;
    assign mem_a     = mem_beat.a;
    assign mem_wd    = mem_beat.wd;
    assign cpu_rd    = mem_rd;
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;
    assign ldr_ack   = ldr_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ldr_rdata  <= '0;
            ldr_rvalid <= 1'b0;
        end else if (ldr_gnt && !ldr_we) begin
            ldr_rdata  <= mem_rd;
            ldr_rvalid <= 1'b1;
        end else begin
            ldr_rvalid <= 1'b0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cpu_stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM on the mem_* side.
// Inputs change on the falling edge; outputs are sampled 3 ns later, before the rising edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        cpu_stall;
    logic        ldr_req, ldr_we;
    logic [31:0] ldr_addr, ldr_wd;
    logic        ldr_ack;
    logic [31:0] ldr_rdata;
    logic        ldr_rvalid;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [15:0] stall_cnt;

    int n_tests;
    int n_fail;

    logic [31:0] ram [0:255];

    dmem_arbiter #(
        .AW (32), .DW (32), .CPU_MAX_RUN (4), .LDR_MAX_RUN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wd     (cpu_wd),
        .cpu_rd     (cpu_rd),
        .cpu_stall  (cpu_stall),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wd     (ldr_wd),
        .ldr_ack    (ldr_ack),
        .ldr_rdata  (ldr_rdata),
        .ldr_rvalid (ldr_rvalid),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = ram[mem_a[9:2]];
    always @(posedge clk) if (mem_we) ram[mem_a[9:2]] <= mem_wd;

    typedef struct {
        logic        rst;
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        lreq, lwe;
        logic [31:0] laddr, lwd;
        logic        e_we;
        logic [31:0] e_a, e_wd;
        logic        e_stall, e_ack, e_rv;
        logic [31:0] e_rdata, e_crd;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic lreq, input logic lwe,
                         input logic [31:0] laddr, input logic [31:0] lwd);
        rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wd = cwd;
        ldr_req = lreq; ldr_we = lwe; ldr_addr = laddr; ldr_wd = lwd;
        #3;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        int   exp_stalls;
        logic ldr_turn;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        //          rst creq cwe caddr   cwd       lreq lwe laddr  lwd      we  a      wd       st ack rv rdata    crd
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5, 1'b1, 1'b1, 32'h20, 32'h1234,
                    1'b0, 32'h10, 32'hA5A5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'hA5A5, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 32'h10, 32'hA5A5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234,
                    1'b1, 32'h20, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        check("reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].lwd);
            check($sformatf("v%0d_mem_we", i),     {31'h0, mem_we},     {31'h0, vecs[i].e_we});
            check($sformatf("v%0d_mem_a", i),      mem_a,               vecs[i].e_a);
            check($sformatf("v%0d_mem_wd", i),     mem_wd,              vecs[i].e_wd);
            check($sformatf("v%0d_cpu_stall", i),  {31'h0, cpu_stall},  {31'h0, vecs[i].e_stall});
            check($sformatf("v%0d_ldr_ack", i),    {31'h0, ldr_ack},    {31'h0, vecs[i].e_ack});
            check($sformatf("v%0d_ldr_rvalid", i), {31'h0, ldr_rvalid}, {31'h0, vecs[i].e_rv});
            check($sformatf("v%0d_ldr_rdata", i),  ldr_rdata,           vecs[i].e_rdata);
            check($sformatf("v%0d_cpu_rd", i),     cpu_rd,              vecs[i].e_crd);
            next_cycle();
        end

        // Simultaneous first requests after reset: CPU first, loader as soon as CPU idles.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h1, 1'b1, 1'b0, 32'h20, 32'h0);
        check("first_cpu_we", {31'h0, mem_we}, 32'h1);
        check("first_ldr_ack", {31'h0, ldr_ack}, 32'h0);
        check("first_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("cpu_idle_ldr_ack", {31'h0, ldr_ack}, 32'h1);
        check("cpu_idle_mem_a", mem_a, 32'h20);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("first_rvalid", {31'h0, ldr_rvalid}, 32'h1);
        check("first_rdata", ldr_rdata, 32'h1234);
        next_cycle();

        // Reset lands on a granted loader read, leaving the arbiter in LDR ownership.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("pre_rst_ack", {31'h0, ldr_ack}, 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("rst_ack", {31'h0, ldr_ack}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("post_rst_rvalid", {31'h0, ldr_rvalid}, 32'h0);
        check("post_rst_cpu_wins", {31'h0, ldr_ack}, 32'h0);
        check("post_rst_stall", {31'h0, cpu_stall}, 32'h0);
        check("post_rst_mem_a", mem_a, 32'h10);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("reissue_ack", {31'h0, ldr_ack}, 32'h1);
        next_cycle();

        // Continuous contention: CPU x4, LDR x4 repeating; stall cycles 4-7, 12-15, 20-21.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hBEEF);
            ldr_turn = ((i % 8) >= 4);
            check($sformatf("cont%0d_stall", i), {31'h0, cpu_stall}, {31'h0, ldr_turn});
            check($sformatf("cont%0d_ack", i),   {31'h0, ldr_ack},   {31'h0, ldr_turn});
            check($sformatf("cont%0d_mem_a", i), mem_a, ldr_turn ? 32'h40 : 32'h10);
            check($sformatf("cont%0d_mem_we", i), {31'h0, mem_we},   {31'h0, ldr_turn});
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_ARB_STATS_EN
        exp_stalls = 10;
`else
        exp_stalls = 0;
`endif
        check("stall_cnt", {16'h0, stall_cnt}, exp_stalls);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter sharing the single-port data RAM between the MIPS core's load/store port and a loader/debug master port. Sits between the core datapath and `RAM` in the top level. Inserts stall cycles into the single-cycle core when the loader holds the RAM, and bounds consecutive ownership so neither side starves.

## Interface
Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- CPU_MAX_RUN, 4, max consecutive CPU beats while loader waits (≥1)
- LDR_MAX_RUN, 4, max consecutive loader beats while CPU waits (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  core load/store this cycle (top drives MemtoReg | MemWrite)
- cpu_we  in  1  core write enable (MemWrite)
- cpu_addr  in  AW  ALUResult
- cpu_wd  in  DW  WriteData
- cpu_rd  out  DW  read data, combinational passthrough of mem_rd
- cpu_stall  out  1  core must hold PC and suppress RegWrite
- ldr_req  in  1  loader beat request, held with addr/we/wd stable until ldr_ack
- ldr_we  in  1  loader write
- ldr_addr  in  AW  loader address
- ldr_wd  in  DW  loader write data
- ldr_ack  out  1  one-cycle pulse, beat performed this cycle
- ldr_rdata  out  DW  registered read data
- ldr_rvalid  out  1  pulse, cycle after a granted loader read
- mem_we  out  1  to RAM WE
- mem_a  out  AW  to RAM A
- mem_wd  out  DW  to RAM WD
- mem_rd  in  DW  from RAM RD (combinational read)
- stall_cnt  out  16  CPU stall-cycle count (see Configuration)

## Operation
- Registered state: last_owner (CPU/LDR), run_cnt (consecutive beats of last_owner, saturates at max(CPU_MAX_RUN, LDR_MAX_RUN)).
- Grant, combinational per cycle:
  - neither request → no grant; mem_we=0, mem_a/mem_wd = CPU inputs.
  - one request → grant it.
  - both → grant the non-last_owner if run_cnt ≥ limit of last_owner; else grant last_owner.
- State update on grant to X: X==last_owner → run_cnt+1 (saturating); else last_owner=X, run_cnt=1. No grant → run_cnt=0, last_owner kept.
- Mux: granted port drives mem_a/mem_wd; mem_we = granted port's we.
- cpu_stall = cpu_req & ~cpu_gnt. ldr_ack = ldr_gnt.
- Granted loader read: ldr_rdata <= mem_rd, ldr_rvalid <= 1 next cycle; else ldr_rvalid <= 0, ldr_rdata holds.
- Loader dropping ldr_req before ack is a protocol violation; behaviour undefined.

## Timing
- CPU beat uncontended: zero latency, no stall.
- Loader beat: ack in the first granted cycle; read data one cycle after ack.
- Worst-case CPU stall under continuous loader traffic: LDR_MAX_RUN cycles; worst-case loader wait: CPU_MAX_RUN cycles.
- Reset values: last_owner=CPU, run_cnt=0, ldr_rdata=0, ldr_rvalid=0, stall_cnt=0.
- While rst=1: no grant, mem_we=0, ldr_ack=0, cpu_stall=0; reset mid-beat drops the beat, loader reissues.
- Simultaneous first requests after reset/idle with last_owner=CPU, run_cnt=0 → CPU wins.

## Configuration
- DMEM_ARB_STATS_EN defined: stall_cnt increments each cycle cpu_stall=1, saturates at 0xFFFF, cleared by rst.
- Undefined: stall_cnt tied to 0, counter logic absent.

## Structure
- Package dmem_arb_pkg: owner enum (OWN_CPU, OWN_LDR), run counter width derived from max limit, STALL_CNT_W=16.
- Sub-module dmem_arb_fair: holds last_owner/run_cnt and produces the grant pair; dmem_arbiter top does muxing, loader read register, stats counter.

## Test plan
- CPU only: cpu_req=1, cpu_we=1, addr=0x10, wd=0xA5A5 → mem_we=1 same cycle, cpu_stall=0; subsequent read returns 0xA5A5 on cpu_rd.
- Loader only write then read addr=0x20 wd=0x1234 → ldr_ack each beat; ldr_rvalid=1, ldr_rdata=0x1234 one cycle after read ack.
- Both continuous, limits 4/4 → grant pattern CPU×4, LDR×4, CPU×4…; cpu_stall high exactly in loader cycles.
- Both first request same cycle after reset → CPU granted, ldr_ack=0 that cycle, loader acked after 4 CPU beats or earlier if CPU idles.
- rst asserted during loader read grant → ldr_ack=0, ldr_rvalid=0 next cycle, state back to CPU/0.
- With DMEM_ARB_STATS_EN, 10 stall cycles → stall_cnt=10; without, stall_cnt=0.
